// File: rtl/darkflash_pkg.sv
// Shared types and constants for the darkflash boot loader.
//   state_t  : loader FSM states
//   ERR_*    : error codes reported on the ERR output
//   rx_state : true for states that accept a byte from the receiver
package darkflash_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_WRITE,
      ST_CSUM,
      ST_DONE,
      ST_FAIL
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_CSUM    = 2'd3;

   function automatic logic rx_state(input state_t s);
      return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/darkflash_if.sv
// Byte-stream and flash write-bus signals of the darkflash loader.
//   RX_DATA/RX_VALID/RX_READY : byte stream from the receiver
//   BUS_ADDR/BUS_WDATA/BUS_BE/BUS_RW/BUS_WAIT : flash write bus
//   master : loader side, slave : receiver + flash side
interface darkflash_if;
   logic [7:0]  RX_DATA;
   logic        RX_VALID;
   logic        RX_READY;
   logic [31:0] BUS_ADDR;
   logic [31:0] BUS_WDATA;
   logic [3:0]  BUS_BE;
   logic        BUS_RW;
   logic        BUS_WAIT;

   modport master (
      input  RX_DATA, RX_VALID, BUS_WAIT,
      output RX_READY, BUS_ADDR, BUS_WDATA, BUS_BE, BUS_RW
   );

   modport slave (
      output RX_DATA, RX_VALID, BUS_WAIT,
      input  RX_READY, BUS_ADDR, BUS_WDATA, BUS_BE, BUS_RW
   );
endinterface

// File: rtl/darkflash_pack.sv
// Packs data bytes little-endian into a 32-bit word and keeps the 8-bit
// running checksum of all data bytes.
//   clk_sys, rst_b : clock, async active-low reset
//   clear          : restart a load (word, byte count and checksum to 0)
//   byte_en        : a data byte is accepted this cycle
//   data_in        : the accepted byte
//   word           : packed word (registered, drives the write data bus)
//   csum           : running checksum modulo 256
//   word_ready     : the byte accepted this cycle completes a word
module darkflash_pack (
   input  logic        clk_sys,
   input  logic        rst_b,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  data_in,
   output logic [31:0] word,
   output logic [7:0]  csum,
   output logic        word_ready
);

   logic [1:0] byte_cnt;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         word     <= '0;
         csum     <= '0;
         byte_cnt <= '0;
      end else if (clear) begin
         word     <= '0;
         csum     <= '0;
         byte_cnt <= '0;
      end else if (byte_en) begin
         // shift right so the first byte ends up in [7:0] after four bytes
         word     <= {data_in, word[31:8]};
         csum     <= csum + data_in;
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   assign word_ready = byte_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/darkflash_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes it as 32-bit
// words into flash at consecutive addresses, verifies a trailing checksum and
// releases the core from reset on a clean load.
//   XCLK, XRES  : clock, async active-low reset
//   START       : one-cycle pulse, begins a load from IDLE/DONE/FAIL
//   bus         : byte stream in, flash write bus out (darkflash_if.master)
//   HOLD        : keeps the core in reset
//   DONE        : load complete with good checksum
//   ERR         : 0 none, 1 bad length, 2 timeout, 3 checksum mismatch
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for START after reset
// ST_LEN0  | receive low byte of word count
// ST_LEN1  | receive high byte of word count, range check
// ST_DATA  | receive data bytes into the packer
// ST_WRITE | drive one flash write, held while BUS_WAIT
// ST_CSUM  | receive and compare checksum byte
// ST_DONE  | load good, core released
// ST_FAIL  | load aborted, ERR holds the cause
module darkflash_loader
   import darkflash_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 512,
   parameter int          TIMEOUT   = 65535
) (
   input  logic              XCLK,
   input  logic              XRES,
   input  logic              START,
   darkflash_if.master       bus,
   output logic              HOLD,
   output logic              DONE,
   output logic [1:0]        ERR
);

   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [9:0]    idx, idx_nxt;
   logic [15:0]   len, len_nxt, len_rx;
   logic [7:0]    len_lo, len_lo_nxt;
   logic [TW-1:0] tmo, tmo_nxt;
   logic [1:0]    err_nxt;
   logic [31:0]   addr_nxt;
   logic          rw_nxt;

   logic          accept, start_ok, data_en, word_ready;
   logic [31:0]   pack_word;
   logic [7:0]    pack_csum;

   assign accept   = bus.RX_VALID && bus.RX_READY;
   assign start_ok = START && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
   assign data_en  = accept && (state == ST_DATA);

   darkflash_pack u_pack (
      .clk_sys    (XCLK),
      .rst_b      (XRES),
      .clear      (start_ok),
      .byte_en    (data_en),
      .data_in    (bus.RX_DATA),
      .word       (pack_word),
      .csum       (pack_csum),
      .word_ready (word_ready)
   );

   // the packer register is stable during WRITE since no bytes are accepted there
   assign bus.BUS_WDATA = pack_word;

   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      len_nxt    = len;
      len_lo_nxt = len_lo;
      tmo_nxt    = tmo;
      err_nxt    = ERR;
      addr_nxt   = bus.BUS_ADDR;
      rw_nxt     = bus.BUS_RW;
      len_rx     = {bus.RX_DATA, len_lo};

      // idle-cycle timer: down-counter reloaded on every accepted byte,
      // not running in WRITE so a stalled flash never times out
      if (rx_state(state)) begin
         if (accept) begin
            tmo_nxt = TMO_LOAD;
         end else if (tmo == '0) begin
            state_nxt = ST_FAIL;
            err_nxt   = ERR_TIMEOUT;
         end else begin
            tmo_nxt = tmo - TW'(1);
         end
      end

      case (state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (START) begin
               state_nxt  = ST_LEN0;
               err_nxt    = ERR_NONE;
               idx_nxt    = '0;
               len_nxt    = '0;
               len_lo_nxt = '0;
               tmo_nxt    = TMO_LOAD;
            end
         end
         ST_LEN0: begin
            if (accept) begin
               len_lo_nxt = bus.RX_DATA;
               state_nxt  = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (accept) begin
               len_nxt = len_rx;
               if ((len_rx == 16'd0) || (len_rx > 16'(MAX_WORDS))) begin
                  state_nxt = ST_FAIL;
                  err_nxt   = ERR_LEN;
               end else begin
                  state_nxt = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (word_ready) begin
               state_nxt = ST_WRITE;
               rw_nxt    = 1'b1;
               addr_nxt  = BASE_ADDR + {20'b0, idx, 2'b00};
            end
         end
         ST_WRITE: begin
            if (!bus.BUS_WAIT) begin
               rw_nxt  = 1'b0;
               idx_nxt = idx + 10'd1;
               if (({6'b0, idx} + 16'd1) == len) state_nxt = ST_CSUM;
               else                               state_nxt = ST_DATA;
            end
         end
         ST_CSUM: begin
            if (accept) begin
               if (bus.RX_DATA == pack_csum) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_FAIL;
                  err_nxt   = ERR_CSUM;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // all outputs are decoded from next-state values and registered
   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         idx          <= '0;
         len          <= '0;
         len_lo       <= '0;
         tmo          <= '0;
         ERR          <= ERR_NONE;
         HOLD         <= 1'b1;
         DONE         <= 1'b0;
         bus.RX_READY <= 1'b0;
         bus.BUS_RW   <= 1'b0;
         bus.BUS_BE   <= 4'b0000;
         bus.BUS_ADDR <= '0;
      end else begin
         idx          <= idx_nxt;
         len          <= len_nxt;
         len_lo       <= len_lo_nxt;
         tmo          <= tmo_nxt;
         ERR          <= err_nxt;
         HOLD         <= (state_nxt != ST_DONE);
         DONE         <= (state_nxt == ST_DONE);
         bus.RX_READY <= rx_state(state_nxt);
         bus.BUS_RW   <= rw_nxt;
         bus.BUS_BE   <= {4{rw_nxt}};
         bus.BUS_ADDR <= addr_nxt;
      end
   end

endmodule

// File: tb/tb_darkflash_loader.sv
module tb_darkflash_loader;
   import darkflash_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       rx_valid = 1'b0;
   logic       bus_wait = 1'b0;
   logic [7:0] rx_data = 8'h00;

   always #5 clk = ~clk;

   darkflash_if if8 ();
   darkflash_if if4 ();

   assign if8.RX_DATA  = rx_data;
   assign if8.RX_VALID = rx_valid;
   assign if8.BUS_WAIT = bus_wait;
   assign if4.RX_DATA  = rx_data;
   assign if4.RX_VALID = rx_valid;
   assign if4.BUS_WAIT = bus_wait;

   logic       hold8, done8, hold4, done4;
   logic [1:0] err8, err4;

   darkflash_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(512), .TIMEOUT(8)) dut8 (
      .XCLK(clk), .XRES(rst_n), .START(start), .bus(if8),
      .HOLD(hold8), .DONE(done8), .ERR(err8));

   darkflash_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(512), .TIMEOUT(4)) dut4 (
      .XCLK(clk), .XRES(rst_n), .START(start), .bus(if4),
      .HOLD(hold4), .DONE(done4), .ERR(err4));

   // both loaders see the same stimulus; use4 selects which one is observed
   bit use4 = 1'b0;
   wire        obs_ready = use4 ? if4.RX_READY  : if8.RX_READY;
   wire        obs_rw    = use4 ? if4.BUS_RW    : if8.BUS_RW;
   wire [3:0]  obs_be    = use4 ? if4.BUS_BE    : if8.BUS_BE;
   wire [31:0] obs_addr  = use4 ? if4.BUS_ADDR  : if8.BUS_ADDR;
   wire [31:0] obs_wdata = use4 ? if4.BUS_WDATA : if8.BUS_WDATA;
   wire        obs_hold  = use4 ? hold4 : hold8;
   wire        obs_done  = use4 ? done4 : done8;
   wire [1:0]  obs_err   = use4 ? err4  : err8;
   wire [73:0] obs_all   = {obs_ready, obs_rw, obs_be, obs_addr, obs_wdata, obs_hold, obs_done, obs_err};
   wire [3:0]  obs_stat  = {obs_hold, obs_done, obs_err};

   localparam logic [73:0] RST_VEC  = {1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00};
   localparam logic [3:0]  ST_GOOD  = {1'b0, 1'b1, ERR_NONE};
   localparam logic [3:0]  ST_BLEN  = {1'b1, 1'b0, ERR_LEN};
   localparam logic [3:0]  ST_BTMO  = {1'b1, 1'b0, ERR_TIMEOUT};
   localparam logic [3:0]  ST_BCSUM = {1'b1, 1'b0, ERR_CSUM};

   int n_checks = 0;
   int n_fail   = 0;
   int wr_count = 0;
   int cyc      = 0;

   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   // write monitor: pops the scoreboard on every completed write and checks
   // that a stalled write keeps address and data stable
   logic [31:0] prev_addr = '0, prev_data = '0;
   bit          prev_stall = 1'b0;
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         n_checks++;
         if (obs_be !== (obs_rw ? 4'hf : 4'h0)) begin
            n_fail++;
            $display("FAIL bus_be: got %h with rw=%b", obs_be, obs_rw);
         end
         if (prev_stall) begin
            n_checks++;
            if (obs_rw !== 1'b1 || obs_addr !== prev_addr || obs_wdata !== prev_data) begin
               n_fail++;
               $display("FAIL stall_hold: got rw=%b addr=%h data=%h required rw=1 addr=%h data=%h",
                        obs_rw, obs_addr, obs_wdata, prev_addr, prev_data);
            end
         end
         if (obs_rw && !bus_wait) begin
            wr_t e;
            wr_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: addr=%h data=%h with empty scoreboard", obs_addr, obs_wdata);
            end else begin
               e = exp_q.pop_front();
               if (obs_addr !== e.addr || obs_wdata !== e.data) begin
                  n_fail++;
                  $display("FAIL write: got addr=%h data=%h required addr=%h data=%h",
                           obs_addr, obs_wdata, e.addr, e.data);
               end
            end
         end
         prev_stall = obs_rw && bus_wait;
         prev_addr  = obs_addr;
         prev_data  = obs_wdata;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // called on a negedge; returns on the negedge after the accepting edge
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!obs_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (!obs_ready) begin
         n_fail++;
         $display("FAIL rx_handshake: rx_ready=%b required 1 within 100 cycles", obs_ready);
      end else begin
         @(negedge clk);
      end
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push_word(input int idx, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
      wr_t e;
      e.addr = 32'h0 + 32'(idx) * 32'd4;
      e.data = {b3, b2, b1, b0};
      exp_q.push_back(e);
   endtask

   task automatic send_load(input logic [15:0] n, input logic [7:0] d[$], input logic [7:0] cs);
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      for (int i = 0; i < d.size(); i++) begin
         if (i % 4 == 3) push_word(i / 4, d[i-3], d[i-2], d[i-1], d[i]);
         send_byte(d[i]);
      end
      send_byte(cs);
   endtask

   function automatic logic [7:0] csum_of(input logic [7:0] d[$]);
      logic [7:0] s;
      s = 8'h00;
      foreach (d[i]) s = s + d[i];
      return s;
   endfunction

   logic [7:0] ref_data[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

   task automatic test_reset();
      repeat (3) tick();
      for (int s = 0; s < 2; s++) begin
         use4 = (s == 1);
         #1;
         n_checks++;
         if (obs_all !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_in_reset: got %h required %h", obs_all, RST_VEC);
         end
      end
      use4 = 1'b0;
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (obs_all !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_after_release: got %h required %h", obs_all, RST_VEC);
      end
   endtask

   task automatic test_good_load();
      int wc0;
      use4 = 1'b0;
      wc0 = wr_count;
      pulse_start();
      n_checks++;
      if (obs_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL start_latency: rx_ready=%b required 1", obs_ready);
      end
      send_load(16'd2, ref_data, 8'h64);
      n_checks++;
      if (obs_stat !== ST_GOOD) begin
         n_fail++;
         $display("FAIL good_load_status: got hold/done/err=%b required %b", obs_stat, ST_GOOD);
      end
      n_checks++;
      if (wr_count - wc0 != 2 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL good_load_writes: got %0d writes, %0d pending, required 2 and 0",
                  wr_count - wc0, exp_q.size());
      end
   endtask

   task automatic test_bad_csum();
      int wc0;
      use4 = 1'b0;
      wc0 = wr_count;
      pulse_start();
      send_load(16'd2, ref_data, 8'h65);
      n_checks++;
      if (obs_stat !== ST_BCSUM) begin
         n_fail++;
         $display("FAIL bad_csum_status: got hold/done/err=%b required %b", obs_stat, ST_BCSUM);
      end
      n_checks++;
      if (wr_count - wc0 != 2 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bad_csum_writes: got %0d writes, %0d pending, required 2 and 0",
                  wr_count - wc0, exp_q.size());
      end
   endtask

   task automatic test_bad_len();
      logic [15:0] lens[2] = '{16'd0, 16'd513};
      use4 = 1'b0;
      foreach (lens[k]) begin
         int wc0;
         wc0 = wr_count;
         pulse_start();
         send_byte(lens[k][7:0]);
         send_byte(lens[k][15:8]);
         n_checks++;
         if (obs_stat !== ST_BLEN || obs_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_len_%0d: got hold/done/err=%b ready=%b required %b ready=0",
                     lens[k], obs_stat, obs_ready, ST_BLEN);
         end
         repeat (4) tick();
         n_checks++;
         if (wr_count != wc0) begin
            n_fail++;
            $display("FAIL bad_len_%0d_nowrite: got %0d writes required 0", lens[k], wr_count - wc0);
         end
      end
   endtask

   task automatic test_stall();
      int wc0;
      use4 = 1'b1;
      wc0 = wr_count;
      pulse_start();
      send_byte(8'd2);
      send_byte(8'd0);
      push_word(0, ref_data[0], ref_data[1], ref_data[2], ref_data[3]);
      bus_wait = 1'b1;
      for (int i = 0; i < 4; i++) send_byte(ref_data[i]);
      // write visible in the cycle after the 4th byte, held 4 cycles in total
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         if (i == 3) bus_wait = 1'b0;
         n_checks++;
         if (obs_rw !== 1'b1 || obs_addr !== 32'h0 || obs_wdata !== 32'h4433_2211) begin
            n_fail++;
            $display("FAIL stall_cycle_%0d: got rw=%b addr=%h data=%h required rw=1 addr=0 data=44332211",
                     i, obs_rw, obs_addr, obs_wdata);
         end
      end
      tick();
      n_checks++;
      if (obs_rw !== 1'b0 || obs_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release: got rw=%b ready=%b required rw=0 ready=1", obs_rw, obs_ready);
      end
      push_word(1, ref_data[4], ref_data[5], ref_data[6], ref_data[7]);
      for (int i = 4; i < 8; i++) send_byte(ref_data[i]);
      send_byte(8'h64);
      n_checks++;
      if (obs_stat !== ST_GOOD) begin
         n_fail++;
         $display("FAIL stall_status: got hold/done/err=%b required %b", obs_stat, ST_GOOD);
      end
      n_checks++;
      if (wr_count - wc0 != 2 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stall_writes: got %0d writes, %0d pending, required 2 and 0",
                  wr_count - wc0, exp_q.size());
      end
      use4 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] d[$];
      int t0, t1;
      use4 = 1'b0;
      for (int i = 0; i < 12; i++) d.push_back(8'($urandom_range(0, 255)));
      pulse_start();
      send_byte(8'd3);
      send_byte(8'd0);
      t0 = cyc;
      for (int i = 0; i < 12; i++) begin
         if (i % 4 == 3) push_word(i / 4, d[i-3], d[i-2], d[i-1], d[i]);
         if (i == 6) start = 1'b1;   // START during DATA must be ignored
         send_byte(d[i]);
         start = 1'b0;
      end
      t1 = cyc;
      send_byte(csum_of(d));
      n_checks++;
      if (t1 - t0 != 14) begin
         n_fail++;
         $display("FAIL b2b_cycles: got %0d cycles for 12 bytes required 14", t1 - t0);
      end
      n_checks++;
      if (obs_stat !== ST_GOOD || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_status: got hold/done/err=%b pending=%0d required %b pending=0",
                  obs_stat, exp_q.size(), ST_GOOD);
      end
   endtask

   task automatic test_timeout();
      use4 = 1'b0;
      pulse_start();
      send_byte(8'd1);
      send_byte(8'd0);
      send_byte(8'hA1);
      send_byte(8'hB2);
      for (int i = 1; i <= 8; i++) begin
         n_checks++;
         if (obs_err !== ERR_NONE) begin
            n_fail++;
            $display("FAIL timeout_early: idle cycle %0d err=%0d required 0", i, obs_err);
         end
         tick();
      end
      n_checks++;
      if (obs_stat !== ST_BTMO || obs_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_fire: got hold/done/err=%b ready=%b required %b ready=0",
                  obs_stat, obs_ready, ST_BTMO);
      end
   endtask

   task automatic test_reset_mid_write();
      use4 = 1'b0;
      pulse_start();
      send_byte(8'd1);
      send_byte(8'd0);
      push_word(0, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
      bus_wait = 1'b1;
      send_byte(8'hDE);
      send_byte(8'hAD);
      send_byte(8'hBE);
      send_byte(8'hEF);
      tick();
      n_checks++;
      if (obs_rw !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_stall_setup: rw=%b required 1", obs_rw);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs_all !== RST_VEC) begin
         n_fail++;
         $display("FAIL reset_mid_write: got %h required %h", obs_all, RST_VEC);
      end
      exp_q.delete();
      bus_wait = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      pulse_start();
      send_load(16'd2, ref_data, 8'h64);
      n_checks++;
      if (obs_stat !== ST_GOOD || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL reload_after_reset: got hold/done/err=%b pending=%0d required %b pending=0",
                  obs_stat, exp_q.size(), ST_GOOD);
      end
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_bad_csum();
      test_bad_len();
      test_stall();
      test_back_to_back();
      test_timeout();
      test_reset_mid_write();
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/darkflash_loader.md
# darkflash_loader

Boot loader that sits directly upstream of the on-chip flash memory and fills it over the data bus before the core runs. It receives a byte stream (typically from a UART receiver) and packs the bytes little-endian into 32-bit words. It writes those words at consecutive word addresses and checks a trailing checksum. It holds the core in reset until a load completes cleanly.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word aligned.
- MAX_WORDS, 512, largest accepted word count; matches flash depth.
- TIMEOUT, 65535, idle cycles allowed between accepted bytes while loading.

Ports:
- XCLK  in  1  single clock; all logic rising-edge.
- XRES  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored otherwise.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  loader accepts a byte this cycle.
- BUS_ADDR  out  32  write byte address.
- BUS_WDATA  out  32  write data.
- BUS_BE  out  4  byte enables; always 4'b1111 during a write, 4'b0000 otherwise.
- BUS_RW  out  1  1 = write cycle (data driven by loader); 0 otherwise.
- BUS_WAIT  in  1  flash stalls the current write.
- HOLD  out  1  keeps the core in reset.
- DONE  out  1  load finished, checksum good.
- ERR  out  2  0 none, 1 bad length, 2 timeout, 3 checksum mismatch.

## Operation
- States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, FAIL.
- Byte transfer: a byte is accepted when RX_VALID && RX_READY.
- RX_READY is 1 only in LEN0, LEN1, DATA and CSUM.
- IDLE: START moves to LEN0. START also clears ERR, DONE, the word index, the byte count, the checksum and the timeout counter.
- LEN0/LEN1: accept the low byte, then the high byte, of the 16-bit word count N.
  - If N == 0 or N > MAX_WORDS, go to FAIL with ERR=1.
  - Otherwise go to DATA.
- DATA: shift bytes in. The first byte goes to bits [7:0], the fourth to [31:24]. After the fourth byte, go to WRITE.
- WRITE: BUS_RW=1, BUS_ADDR=BASE_ADDR+4*idx, BUS_WDATA=packed word. The write completes in the first cycle with BUS_WAIT=0. Then idx increments.
  - If idx+1 == N, go to CSUM.
  - Otherwise return to DATA.
- Checksum: an 8-bit running sum, modulo 256, of every data byte (length bytes excluded).
- CSUM: accept one byte.
  - If it equals the running sum, go to DONE.
  - Otherwise go to FAIL with ERR=3.
- Timeout: in LEN0, LEN1, DATA and CSUM, a counter counts cycles with no accepted byte. It resets on every accepted byte.
  - On reaching TIMEOUT, go to FAIL with ERR=2.
  - The counter is frozen in WRITE; a stalled flash is not a timeout.
- DONE: DONE=1, HOLD=0.
- FAIL: HOLD stays 1; ERR holds its code.
- DONE and FAIL both stay until START or reset.
- START in LEN0, LEN1, DATA, WRITE or CSUM is ignored.

## Timing
- Reset values: state IDLE, RX_READY=0, BUS_RW=0, BUS_BE=0, BUS_ADDR=0, BUS_WDATA=0, HOLD=1, DONE=0, ERR=0.
- Reset mid-load aborts immediately. Words already written stay in flash.
- All outputs are registered; there is no combinational path from input to output.
- START is seen at edge k; LEN0 and RX_READY=1 are visible in cycle k+1.
- The fourth data byte is accepted at edge k; BUS_RW=1 in cycle k+1.
  - With BUS_WAIT=0, RX_READY=1 again in cycle k+2.
  - Minimum is 5 cycles per word with back-to-back bytes.
- While BUS_WAIT=1, BUS_ADDR, BUS_WDATA, BUS_BE and BUS_RW are held stable.
- The CSUM byte is accepted at edge k; DONE=1 and HOLD=0 (or ERR=3) in cycle k+1.
- Timeout fires on the TIMEOUT-th consecutive idle cycle.
- idx is 10 bits and never wraps, because N ≤ MAX_WORDS is checked first.

## Structure
- Shared package darkflash_pkg:
  - state enum;
  - ERR code constants (ERR_NONE, ERR_LEN, ERR_TIMEOUT, ERR_CSUM).
- One sub-module, darkflash_pack. It holds the byte-to-word shift register, the 2-bit byte counter and the running checksum. It is cleared by START and produces word_ready after the fourth byte.

## Test plan
- N=2, bytes 11 22 33 44 55 66 77 88, checksum 0x64:
  - writes 0x44332211 to addr 0x0 and 0x88776655 to addr 0x4;
  - DONE=1, HOLD=0.
- Same load with checksum 0x65: both writes occur; ERR=3, HOLD=1, DONE=0.
- Length 0x0000, and separately length 513: ERR=1 with no bus write.
- BUS_WAIT held for 3 cycles on word 0: address and data stable for 4 cycles, one write only, and no timeout at TIMEOUT=4.
- TIMEOUT=8, stop sending after 2 data bytes: ERR=2 on the 8th idle cycle.
- Reset asserted during a WRITE stall: every output is at its reset value immediately. A following START and a full load then succeed.
